// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, one-deep request tracking and a
// DEPTH-entry {pc, inst} prefetch FIFO presented to decode with valid/ready.
module fetch_queue #(
  parameter int                 XLEN     = 32,
  parameter int                 IM_AW    = 14,
  parameter int                 DEPTH    = 4,
  parameter logic [XLEN-1:0]    RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       im_en,
  output logic [IM_AW-1:0]           im_addr,
  input  logic [31:0]                im_rdata,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [XLEN-1:0]            inst_pc,
  output logic [31:0]                inst,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              OW      = PW + 1;
  localparam logic [XLEN-1:0] PC_MASK = ~(XLEN'(3));
  localparam logic [OW:0]     DEPTH_W = (OW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] infl_pc_q, infl_pc_d;
  logic            inflight_q, inflight_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   occ_q, occ_d;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];

  logic            pop, push, issue, flush;
  logic [OW:0]     credit;
  logic [XLEN-1:0] issue_pc;

  always_comb begin
    flush      = redirect_valid & ~rst;
    inst_valid = (occ_q != '0) & ~redirect_valid;
    pop        = inst_valid & inst_ready;
    // A response arriving in a redirect cycle belongs to the stale stream.
    push       = inflight_q & ~redirect_valid;
    // Entries held plus the one response still owed must leave room.
    credit     = {1'b0, occ_q} + (OW+1)'(inflight_q) - (OW+1)'(pop);
    issue      = ~rst & (redirect_valid | (credit < DEPTH_W));
    issue_pc   = flush ? (redirect_pc & PC_MASK) : fetch_pc_q;

    fetch_pc_d = issue ? issue_pc + XLEN'(4) : fetch_pc_q;
    inflight_d = issue;
    infl_pc_d  = issue ? issue_pc : infl_pc_q;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      occ_d = occ_q + OW'(push) - OW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC & PC_MASK;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  // Data storage carries no reset; occupancy gates every use of it.
  always_ff @(posedge clk) begin
    infl_pc_q <= infl_pc_d;
    if (push) begin
      pc_mem[wr_ptr_q]   <= infl_pc_q;
      inst_mem[wr_ptr_q] <= im_rdata;
    end
  end

  assign im_en     = issue;
  assign im_addr   = issue_pc[IM_AW+1:2];
  assign occupancy = occ_q;
  assign inst_pc   = (occ_q != '0) ? pc_mem[rd_ptr_q]   : '0;
  assign inst      = (occ_q != '0) ? inst_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random ready/redirect traffic,
// with a scoreboard holding the expected in-order {pc, inst} stream.
module tb_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          IM_AW    = 14;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          OW       = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              im_en;
  logic [IM_AW-1:0]  im_addr;
  logic [31:0]       im_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [XLEN-1:0]   inst_pc;
  logic [31:0]       inst;
  logic [OW-1:0]     occupancy;

  fetch_queue #(.XLEN(XLEN), .IM_AW(IM_AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .im_en(im_en), .im_addr(im_addr), .im_rdata(im_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc),
    .inst(inst), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: word a holds 0x1000_0000 + a.
  always @(posedge clk) if (im_en) im_rdata <= 32'h1000_0000 + 32'(im_addr);
  initial im_rdata = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [IM_AW-1:0] a;
    a = pc[IM_AW+1:2];
    return 32'h1000_0000 + 32'(a);
  endfunction

  int vectors;
  int miscompares;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [31:0] pc; logic [31:0] word; } item_t;
  item_t       exp_q[$];
  logic [31:0] gen_pc;

  task automatic topup();
    while (exp_q.size() < 4) begin
      exp_q.push_back('{gen_pc, mem_word(gen_pc)});
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic flush_model(input logic [31:0] tgt);
    exp_q.delete();
    gen_pc = tgt & ~32'h3;
    topup();
  endtask

  // Advance to just after the next rising edge; sample at falling edges.
  task automatic cyc();
    @(posedge clk);
    #1;
    topup();
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: every accepted instruction must be the next one in the stream.
  always @(negedge clk) begin
    item_t it;
    if (!rst) begin
      check("occ_bound", 32'(occupancy <= DEPTH), 32'd1);
      if (occupancy == '0) begin
        check("empty_inst", inst, 32'h0);
        check("empty_pc", inst_pc, 32'h0);
      end
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd0, 32'd1);
        end else begin
          it = exp_q.pop_front();
          check("pop_pc", inst_pc, it.pc);
          check("pop_inst", inst, it.word);
        end
      end
    end
  end

  logic [31:0] hold_pc;
  bit          seen;

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    flush_model(RESET_PC);

    // Reset state
    #3;
    check("rst_im_en", im_en, 32'd0);
    check("rst_im_addr", im_addr, 32'(RESET_PC[IM_AW+1:2]));
    check("rst_valid", inst_valid, 32'd0);
    check("rst_occ", occupancy, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    cyc();
    rst = 1'b0;
    flush_model(RESET_PC);

    // Startup latency and steady streaming
    mid();
    check("st0_im_en", im_en, 32'd1);
    check("st0_addr", im_addr, 32'd0);
    check("st0_valid", inst_valid, 32'd0);
    cyc(); mid();
    check("st1_addr", im_addr, 32'd1);
    check("st1_valid", inst_valid, 32'd0);
    cyc(); mid();
    check("st2_addr", im_addr, 32'd2);
    check("st2_valid", inst_valid, 32'd1);
    check("st2_pc", inst_pc, 32'h0);
    for (int i = 0; i < 6; i++) begin
      cyc(); mid();
      check("thru_valid", inst_valid, 32'd1);
      check("thru_occ", 32'(occupancy <= 1), 32'd1);
    end

    // Stall for 10 cycles
    cyc();
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mid();
      check("stall_valid", inst_valid, 32'd1);
      if (i == 0) hold_pc = inst_pc;
      else check("stall_hold", inst_pc, hold_pc);
      if (i == 9) begin
        check("stall_occ_full", occupancy, 32'(DEPTH));
        check("stall_im_en", im_en, 32'd0);
      end
      cyc();
    end

    // One pop, then redirect with three entries held and one in flight
    inst_ready = 1'b1;
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h200; flush_model(32'h200);
    mid();
    check("rd_pre_occ", occupancy, 32'd3);
    check("rd_im_en", im_en, 32'd1);
    check("rd_im_addr", im_addr, 32'h80);
    check("rd_valid", inst_valid, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    mid();
    check("rd1_occ", occupancy, 32'd0);
    check("rd1_valid", inst_valid, 32'd0);
    cyc(); mid();
    check("rd2_valid", inst_valid, 32'd1);
    check("rd2_pc", inst_pc, 32'h200);
    for (int i = 0; i < 3; i++) cyc();

    // Back-to-back redirects; low target bits ignored
    redirect_valid = 1'b1; redirect_pc = 32'h40; flush_model(32'h40);
    mid();
    check("bb0_addr", im_addr, 32'h10);
    cyc();
    redirect_pc = 32'h83; flush_model(32'h83);
    mid();
    check("bb1_addr", im_addr, 32'h20);
    check("bb1_valid", inst_valid, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    mid();
    check("bb2_valid", inst_valid, 32'd0);
    cyc(); mid();
    check("bb3_valid", inst_valid, 32'd1);
    check("bb3_pc", inst_pc, 32'h80);
    for (int i = 0; i < 3; i++) cyc();

    // Asynchronous reset in the middle of a full stall
    inst_ready = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    mid();
    check("ar_pre_occ", occupancy, 32'(DEPTH));
    cyc();
    rst = 1'b1;
    flush_model(RESET_PC);
    #1;
    check("ar_im_en", im_en, 32'd0);
    check("ar_valid", inst_valid, 32'd0);
    check("ar_occ", occupancy, 32'd0);
    cyc(); cyc();
    rst = 1'b0; inst_ready = 1'b1;
    flush_model(RESET_PC);
    mid();
    check("ar_restart_addr", im_addr, 32'(RESET_PC[IM_AW+1:2]));
    cyc(); cyc(); mid();
    check("ar_restart_valid", inst_valid, 32'd1);
    check("ar_restart_pc", inst_pc, RESET_PC & ~32'h3);
    cyc();

    // PC wrap at the top of the address space, one per cycle
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; flush_model(32'hFFFF_FFF8);
    cyc();
    redirect_valid = 1'b0;
    cyc();
    mid(); check("wrap0_valid", inst_valid, 32'd1); check("wrap0_pc", inst_pc, 32'hFFFF_FFF8);
    cyc();
    mid(); check("wrap1_valid", inst_valid, 32'd1); check("wrap1_pc", inst_pc, 32'hFFFF_FFFC);
    cyc();
    mid(); check("wrap2_valid", inst_valid, 32'd1); check("wrap2_pc", inst_pc, 32'h0000_0000);
    cyc();

    // Random ready and redirect traffic
    for (int i = 0; i < 800; i++) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
        flush_model(redirect_pc);
      end else begin
        redirect_valid = 1'b0;
      end
      cyc();
    end

    // Drain: the stream must resume within a bounded number of cycles
    redirect_valid = 1'b0; inst_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      mid();
      if (inst_valid) seen = 1'b1;
      cyc();
    end
    check("drain_live", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
